// File: rtl/ecc_pkg.sv
// Shared ECC constants: codeword geometry for encoder/decoder and frame sync defaults.
package ecc_pkg;

    localparam int unsigned CW_WIDTH     = 18;
    localparam int unsigned DATA_WIDTH   = 12;
    localparam int unsigned SYNC_LEN     = 8;
    localparam logic [SYNC_LEN-1:0] SYNC_WORD = 8'hA5;
    localparam int unsigned CW_PER_FRAME = 4;
    localparam int unsigned MISS_MAX     = 2;
    localparam int unsigned MISS_CNT_W   = 8;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK_SYNC
    } deframer_state_e;

endpackage

// File: rtl/ecc_sync_match.sv
// Sync-word shift window with clear; the window includes the bit currently presented.
module ecc_sync_match
    import ecc_pkg::*;
#(
    parameter int unsigned         LEN     = SYNC_LEN,
    parameter logic [LEN-1:0]      PATTERN = SYNC_WORD
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           shift,
    input  logic           clr,
    input  logic           bit_in,
    output logic [LEN-1:0] window_c,
    output logic           match_c
);

    // Only LEN-1 bits need storing: the newest bit comes straight from bit_in.
    logic [LEN-2:0] sr;

    assign window_c = {sr, bit_in};
    assign match_c  = (window_c == PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (shift) begin
            sr <= window_c[LEN-2:0];
        end
    end

endmodule

// File: rtl/ecc_rx_deframer.sv
// Serial receive deframer: hunts for sync, tracks it with flywheel, and assembles codewords.
module ecc_rx_deframer
    import ecc_pkg::*;
#(
    parameter int unsigned              CW_WIDTH     = ecc_pkg::CW_WIDTH,
    parameter int unsigned              SYNC_LEN     = ecc_pkg::SYNC_LEN,
    parameter logic [SYNC_LEN-1:0]      SYNC_WORD    = ecc_pkg::SYNC_WORD,
    parameter int unsigned              CW_PER_FRAME = ecc_pkg::CW_PER_FRAME,
    parameter int unsigned              MISS_MAX     = ecc_pkg::MISS_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic [CW_WIDTH-1:0]   cw_data,
    output logic                  cw_valid,
    output logic                  locked,
    output logic                  frame_start,
    output logic                  sync_loss,
    output logic [MISS_CNT_W-1:0] sync_miss_cnt
);

    localparam int unsigned BIT_MAX   = (CW_WIDTH > SYNC_LEN) ? CW_WIDTH : SYNC_LEN;
    localparam int unsigned BIT_CNT_W = $clog2(BIT_MAX);
    localparam int unsigned CW_CNT_W  = $clog2(CW_PER_FRAME + 1);
    localparam int unsigned MISS_W    = $clog2(MISS_MAX + 1);

    deframer_state_e        state;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [CW_CNT_W-1:0]    cw_cnt;
    logic [MISS_W-1:0]      miss_run;
    logic [CW_WIDTH-2:0]    asm_q;

    logic [SYNC_LEN-1:0]    window_c;
    logic                   match_c;
    logic                   shift_c;
    logic                   clr_c;
    logic                   last_cw_bit_c;
    logic                   last_sync_bit_c;
    logic                   last_cw_c;
    logic                   sync_ok_c;
    logic                   lose_c;

    assign last_cw_bit_c   = (bit_cnt == BIT_CNT_W'(CW_WIDTH - 1));
    assign last_sync_bit_c = (bit_cnt == BIT_CNT_W'(SYNC_LEN - 1));
    assign last_cw_c       = (cw_cnt == CW_CNT_W'(CW_PER_FRAME - 1));
    assign sync_ok_c       = (window_c == SYNC_WORD);
    assign lose_c          = (miss_run == MISS_W'(MISS_MAX - 1));

    // The window only advances while looking for sync; payload bits never reach it.
    assign shift_c = bit_valid && ((state == HUNT) || (state == CHECK_SYNC));
    assign clr_c   = bit_valid && (state == CHECK_SYNC) && last_sync_bit_c
                     && !sync_ok_c && lose_c;

    ecc_sync_match #(
        .LEN     (SYNC_LEN),
        .PATTERN (SYNC_WORD)
    ) u_sync_match (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift    (shift_c),
        .clr      (clr_c),
        .bit_in   (bit_in),
        .window_c (window_c),
        .match_c  (match_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HUNT;
            bit_cnt       <= '0;
            cw_cnt        <= '0;
            miss_run      <= '0;
            asm_q         <= '0;
            cw_data       <= '0;
            cw_valid      <= 1'b0;
            locked        <= 1'b0;
            frame_start   <= 1'b0;
            sync_loss     <= 1'b0;
            sync_miss_cnt <= '0;
        end else begin
            cw_valid    <= 1'b0;
            frame_start <= 1'b0;
            sync_loss   <= 1'b0;
            if (bit_valid) begin
                unique case (state)
                    HUNT: begin
                        if (match_c) begin
                            state       <= PAYLOAD;
                            locked      <= 1'b1;
                            frame_start <= 1'b1;
                            miss_run    <= '0;
                            bit_cnt     <= '0;
                            cw_cnt      <= '0;
                        end
                    end
                    PAYLOAD: begin
                        asm_q <= {asm_q[CW_WIDTH-3:0], bit_in};
                        if (last_cw_bit_c) begin
                            bit_cnt  <= '0;
                            cw_data  <= {asm_q, bit_in};
                            cw_valid <= 1'b1;
                            if (last_cw_c) begin
                                cw_cnt <= '0;
                                state  <= CHECK_SYNC;
                            end else begin
                                cw_cnt <= cw_cnt + CW_CNT_W'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                    CHECK_SYNC: begin
                        if (last_sync_bit_c) begin
                            bit_cnt <= '0;
                            if (sync_ok_c) begin
                                frame_start <= 1'b1;
                                miss_run    <= '0;
                                state       <= PAYLOAD;
                            end else begin
                                if (sync_miss_cnt != '1) begin
                                    sync_miss_cnt <= sync_miss_cnt + MISS_CNT_W'(1);
                                end
                                if (lose_c) begin
                                    sync_loss <= 1'b1;
                                    locked    <= 1'b0;
                                    miss_run  <= '0;
                                    state     <= HUNT;
                                end else begin
                                    miss_run <= miss_run + MISS_W'(1);
                                    state    <= PAYLOAD;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ecc_rx_deframer.sv
// Self-checking bench for ecc_rx_deframer: frame-position model plus directed literal checks.
module tb_ecc_rx_deframer;

    logic        clk;
    logic        rst_n;
    logic        bit_in;
    logic        bit_valid;
    logic [17:0] cw_data;
    logic        cw_valid;
    logic        locked;
    logic        frame_start;
    logic        sync_loss;
    logic [7:0]  sync_miss_cnt;

    int total = 0;
    int bad   = 0;
    int fs_n  = 0;
    int sl_n  = 0;
    logic [17:0] got_cw[$];

    ecc_rx_deframer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .cw_data       (cw_data),
        .cw_valid      (cw_valid),
        .locked        (locked),
        .frame_start   (frame_start),
        .sync_loss     (sync_loss),
        .sync_miss_cnt (sync_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model tracks position within a locked frame: 72 payload bits then 8 sync bits.
    typedef struct {
        bit          locked;
        int          pos;
        int          hist;
        int          run;
        int          misses;
        int          acc;
        logic [17:0] cw;
        bit          cwv;
        bit          fs;
        bit          sl;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t m_reset();
        mstate_t r;
        r.locked = 0; r.pos = 0; r.hist = 0; r.run = 0; r.misses = 0;
        r.acc = 0; r.cw = '0; r.cwv = 0; r.fs = 0; r.sl = 0;
        return r;
    endfunction

    function automatic mstate_t m_idle(mstate_t s);
        mstate_t r = s;
        r.cwv = 0; r.fs = 0; r.sl = 0;
        return r;
    endfunction

    function automatic mstate_t m_step(mstate_t s, logic b);
        mstate_t r = s;
        r.cwv = 0; r.fs = 0; r.sl = 0;
        r.hist = ((s.hist << 1) | int'(b)) & 'hFF;
        if (!s.locked) begin
            if (r.hist == 'hA5) begin
                r.locked = 1; r.pos = 0; r.run = 0; r.fs = 1;
            end
        end else if (s.pos < 72) begin
            r.acc = ((s.acc << 1) | int'(b)) & 'h3FFFF;
            r.pos = s.pos + 1;
            if (r.pos % 18 == 0) begin
                r.cw  = 18'(r.acc);
                r.cwv = 1;
            end
        end else begin
            r.pos = s.pos + 1;
            if (r.pos == 80) begin
                r.pos = 0;
                if (r.hist == 'hA5) begin
                    r.fs  = 1;
                    r.run = 0;
                end else begin
                    r.misses = (s.misses < 255) ? s.misses + 1 : 255;
                    r.run    = s.run + 1;
                    if (r.run >= 2) begin
                        r.locked = 0; r.sl = 1; r.hist = 0; r.run = 0;
                    end
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         m <= m_reset();
        else if (bit_valid) m <= m_step(m, bit_in);
        else                m <= m_idle(m);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, plus event capture for literal checks.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cw_valid",      32'(cw_valid),      32'(m.cwv));
            chk("cw_data",       32'(cw_data),       32'(m.cw));
            chk("locked",        32'(locked),        32'(m.locked));
            chk("frame_start",   32'(frame_start),   32'(m.fs));
            chk("sync_loss",     32'(sync_loss),     32'(m.sl));
            chk("sync_miss_cnt", 32'(sync_miss_cnt), 32'(m.misses));
            if (cw_valid)    got_cw.push_back(cw_data);
            if (frame_start) fs_n++;
            if (sync_loss)   sl_n++;
        end
    end

    task automatic send(input logic [31:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            bit_in    = v[i];
            bit_valid = 1'b1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bit_valid = 1'b0;
                bit_in    = 1'($urandom);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bit_valid = 1'b0;
            bit_in    = 1'($urandom);
        end
    endtask

    task automatic frame(input logic [7:0] s, input logic [17:0] c0, input logic [17:0] c1,
                         input logic [17:0] c2, input logic [17:0] c3, input int gap);
        send(32'(s), 8, gap);
        send(32'(c0), 18, gap);
        send(32'(c1), 18, gap);
        send(32'(c2), 18, gap);
        send(32'(c3), 18, gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_cw.delete();
        fs_n = 0;
        sl_n = 0;
    endtask

    task automatic chk_cw(input string name, input int idx, input logic [17:0] exp);
        if (idx < got_cw.size()) chk(name, 32'(got_cw[idx]), 32'(exp));
        else                     chk(name, 32'hDEAD_0000, 32'(exp));
    endtask

    initial begin
        rst_n     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        #1;
        chk("rst_cw_valid", 32'(cw_valid), 32'd0);
        chk("rst_locked",   32'(locked),   32'd0);
        chk("rst_cw_data",  32'(cw_data),  32'd0);
        chk("rst_miss_cnt", 32'(sync_miss_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Test 1: continuous stream, junk then one frame; pin exact latencies.
        send(32'h3C, 8, 0);
        send(32'hA5, 8, 0);
        @(posedge clk); #1;
        chk("t1_fs_pulse",  32'(frame_start), 32'd1);
        chk("t1_locked",    32'(locked),      32'd1);
        send(32'h00001, 18, 0);
        @(posedge clk); #1;
        chk("t1_cwv_lat",   32'(cw_valid), 32'd1);
        chk("t1_cw0_lat",   32'(cw_data),  32'h00001);
        send(32'h3FFFF, 18, 0);
        send(32'h2AAAA, 18, 0);
        send(32'h15555, 18, 0);
        idle(4);
        chk("t1_ncw", 32'(got_cw.size()), 32'd4);
        chk_cw("t1_cw0", 0, 18'h00001);
        chk_cw("t1_cw1", 1, 18'h3FFFF);
        chk_cw("t1_cw2", 2, 18'h2AAAA);
        chk_cw("t1_cw3", 3, 18'h15555);
        chk("t1_fs_n", 32'(fs_n), 32'd1);

        // Test 2: same frame with one valid bit in three.
        do_reset();
        frame(8'hA5, 18'h00001, 18'h3FFFF, 18'h2AAAA, 18'h15555, 2);
        idle(4);
        chk("t2_ncw", 32'(got_cw.size()), 32'd4);
        chk_cw("t2_cw0", 0, 18'h00001);
        chk_cw("t2_cw3", 3, 18'h15555);
        chk("t2_cw_hold", 32'(cw_data), 32'h15555);

        // Test 3: one bad sync is flywheeled; the following good sync clears the run.
        do_reset();
        frame(8'hA5, 18'h00001, 18'h3FFFF, 18'h2AAAA, 18'h15555, 0);
        frame(8'hA4, 18'h0ABCD, 18'h12345, 18'h3C3C3, 18'h00F0F, 0);
        idle(2);
        chk("t3_miss1",  32'(sync_miss_cnt), 32'd1);
        chk("t3_locked", 32'(locked), 32'd1);
        chk("t3_ncw",    32'(got_cw.size()), 32'd8);
        chk_cw("t3_cw4", 4, 18'h0ABCD);
        chk_cw("t3_cw7", 7, 18'h00F0F);
        frame(8'hA5, 18'h11111, 18'h22222, 18'h33333, 18'h04444, 0);
        send(32'h00, 8, 0);
        idle(2);
        chk("t3_miss2",   32'(sync_miss_cnt), 32'd2);
        chk("t3_locked2", 32'(locked), 32'd1);
        chk("t3_sl_n",    32'(sl_n), 32'd0);

        // Test 4: two consecutive bad syncs drop lock; relock on A5.
        do_reset();
        frame(8'hA5, 18'h00001, 18'h3FFFF, 18'h2AAAA, 18'h15555, 0);
        frame(8'h00, 18'h00001, 18'h3FFFF, 18'h2AAAA, 18'h15555, 0);
        send(32'hFF, 8, 0);
        @(posedge clk); #1;
        chk("t4_sl_pulse", 32'(sync_loss), 32'd1);
        chk("t4_unlocked", 32'(locked),    32'd0);
        chk("t4_miss",     32'(sync_miss_cnt), 32'd2);
        send(32'h00000, 18, 0);
        idle(2);
        chk("t4_no_cw", 32'(got_cw.size()), 32'd8);
        chk("t4_sl_n",  32'(sl_n), 32'd1);
        send(32'hA5, 8, 0);
        send(32'h12345, 18, 0);
        idle(2);
        chk("t4_relock", 32'(locked), 32'd1);
        chk("t4_ncw",    32'(got_cw.size()), 32'd9);
        chk_cw("t4_cw8", 8, 18'h12345);

        // Test 5: sync pattern embedded in payload is just data.
        do_reset();
        frame(8'hA5, 18'h00A50, 18'h00A50, 18'h2AAAA, 18'h15555, 0);
        idle(2);
        chk("t5_fs_n", 32'(fs_n), 32'd1);
        chk("t5_ncw",  32'(got_cw.size()), 32'd4);
        chk_cw("t5_cw0", 0, 18'h00A50);
        chk_cw("t5_cw1", 1, 18'h00A50);

        // Test 6: reset mid-codeword discards partial bits and requires a fresh sync.
        do_reset();
        send(32'hA5, 8, 0);
        send(32'h2BCDE, 18, 0);
        send(32'h3FFFF >> 9, 9, 0);
        @(negedge clk);
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        #1;
        chk("t6_rst_locked", 32'(locked),   32'd0);
        chk("t6_rst_cwdata", 32'(cw_data),  32'd0);
        chk("t6_rst_cwv",    32'(cw_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        got_cw.delete();
        send(32'h1FF, 9, 0);
        idle(3);
        chk("t6_no_cw",  32'(got_cw.size()), 32'd0);
        chk("t6_locked", 32'(locked), 32'd0);
        send(32'hA5, 8, 0);
        idle(2);
        chk("t6_relock", 32'(locked), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
